// File: rtl/imem_arbiter_if.sv
// -----------------------------------------------------------------------------
// imem_arbiter_if
//
// Purpose: bundles every bus signal around the instruction-memory arbiter:
// the fetch requester port (f_*), the loader requester port (l_*) and the
// single-port memory side (mem_*).
//
// Modports:
//   slave  - the arbiter's view: requests, addresses, write data and
//            mem_rdata are inputs; grants, read responses and the memory
//            command are outputs.
//   master - the environment's view (requesters plus memory array), which is
//            the mirror image of slave.
//
// Parameter ADDR_WIDTH sets the width of the word address sent to memory and
// must match the arbiter's ADDR_WIDTH.
// -----------------------------------------------------------------------------
interface imem_arbiter_if #(
    parameter int ADDR_WIDTH = 10
);
    // Fetch requester (read-only)
    logic                  f_req;
    logic [31:0]           f_addr;
    logic                  f_gnt;
    logic                  f_rvalid;
    logic [31:0]           f_rdata;

    // Loader requester (read/write)
    logic                  l_req;
    logic                  l_we;
    logic [31:0]           l_addr;
    logic [31:0]           l_wdata;
    logic                  l_gnt;
    logic                  l_rvalid;
    logic [31:0]           l_rdata;

    // Memory array port
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_rvalid, f_rdata,
        input  l_req, l_we, l_addr, l_wdata,
        output l_gnt, l_rvalid, l_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output f_req, f_addr,
        input  f_gnt, f_rvalid, f_rdata,
        output l_req, l_we, l_addr, l_wdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Purpose: shares one synchronous-read word memory between the IF-stage fetch
// unit (read-only) and the program loader (read/write). At most one access is
// granted per cycle, grants are combinational, and read data comes back one
// cycle after the grant, routed to whichever requester owned the read.
// The loader has priority over fetch.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low reset
//   bus    - imem_arbiter_if.slave: f_* fetch port, l_* loader port,
//            mem_* memory port
//
// Parameters:
//   ADDR_WIDTH - word-address bits driven to memory (default 10 -> 1024 words)
//   MAX_BURST  - consecutive loader grants tolerated while fetch waits
//                (1..255, used only in the fairness build)
//
// Configuration macro:
//   IMEM_ARB_FAIRNESS_EN - when defined, a burst counter forces a fetch grant
//                          after MAX_BURST consecutive loader grants that
//                          kept a pending fetch waiting. When undefined,
//                          strict loader priority applies and fetch may starve.
// -----------------------------------------------------------------------------
module imem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = 4
) (
    input  logic           clk,
    input  logic           reset,
    imem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_e;

    owner_e owner_q, owner_d;
    logic   f_gnt;
    logic   l_gnt;
    logic   fair_fire;

`ifdef IMEM_ARB_FAIRNESS_EN
    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    logic [7:0] burst_cnt_q, burst_cnt_d;

    // Fetch is forced through once the loader has held it off MAX_BURST times
    // in a row and both sides are still asking.
    assign fair_fire = bus.f_req && bus.l_req && (burst_cnt_q == BURST_LIMIT);

    // The count only advances while fetch is actually being held off.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (!bus.f_req || f_gnt) begin
            burst_cnt_d = 8'd0;
        end else if (l_gnt) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt_q <= 8'd0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign fair_fire = 1'b0;
`endif

    // Grants are gated with reset so nothing reaches memory while it is low.
    always_comb begin
        l_gnt = reset && bus.l_req && !fair_fire;
        f_gnt = reset && bus.f_req && (!bus.l_req || fair_fire);
    end

    // Owner state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Next owner: only reads produce a response; loader writes leave NONE.
    always_comb begin
        owner_d = OWN_NONE;
        if (f_gnt) begin
            owner_d = OWN_FETCH;
        end else if (l_gnt && !bus.l_we) begin
            owner_d = OWN_LOAD;
        end
    end

    // Outputs: memory command from this cycle's grant, responses from the
    // owner captured at the previous edge. Address bits [1:0] and everything
    // above the word range are dropped so accesses wrap modulo memory size.
    always_comb begin
        bus.f_gnt     = f_gnt;
        bus.l_gnt     = l_gnt;
        bus.mem_en    = f_gnt || l_gnt;
        bus.mem_we    = l_gnt && bus.l_we;
        bus.mem_addr  = l_gnt ? bus.l_addr[ADDR_WIDTH+1:2] : bus.f_addr[ADDR_WIDTH+1:2];
        bus.mem_wdata = bus.l_wdata;
        bus.f_rvalid  = (owner_q == OWN_FETCH);
        bus.l_rvalid  = (owner_q == OWN_LOAD);
        bus.f_rdata   = (owner_q == OWN_FETCH) ? bus.mem_rdata : 32'h0;
        bus.l_rdata   = (owner_q == OWN_LOAD)  ? bus.mem_rdata : 32'h0;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Single-port instruction-memory arbiter that shares one synchronous-read word memory between two requesters: the IF-stage fetch unit (read-only) and the program loader (read/write, used for boot and debug download). It sits between the IF stage and the memory array and grants at most one access per cycle. It returns read data one cycle after the grant and tags each response to its owner. Loader has priority; an optional fairness guard bounds fetch starvation.

## Interface
- ADDR_WIDTH, 10: word-address bits driven to memory (1024 words).
- MAX_BURST, 4: consecutive loader grants allowed while fetch waits (fairness build only); range 1..255.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch read request.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch request accepted this cycle (combinational).
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  32  fetch read data.
- l_req  in  1  loader request.
- l_we  in  1  loader write (1) / read (0).
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader request accepted this cycle (combinational).
- l_rvalid  out  1  loader read data valid.
- l_rdata  out  32  loader read data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0.

## Operation
- Per cycle, a grant goes to at most one requester. Only l_req: loader. Only f_req: fetch. Both: loader, unless the fairness guard fires.
- mem_en = f_gnt | l_gnt. mem_we = l_gnt & l_we. mem_addr = granted addr[ADDR_WIDTH+1:2]. mem_wdata = l_wdata.
- Address bits [1:0] and bits above ADDR_WIDTH+1 are ignored, so accesses wrap modulo memory size.
- The owner register (NONE/FETCH/LOAD) is loaded each cycle: FETCH if f_gnt, LOAD if l_gnt & ~l_we, else NONE.
- f_rvalid = (owner==FETCH); l_rvalid = (owner==LOAD).
- f_rdata/l_rdata = mem_rdata when the matching rvalid is set, else 32'h0.
- Loader writes produce no rvalid. A loader write to address A followed by a fetch of A returns the new data.
- Requesters must hold req/addr/wdata stable until gnt. Deasserting req before gnt is legal, and the request is simply dropped.

## Timing
- Grant latency 0 cycles (same-cycle combinational). Read data latency 1 cycle after the grant edge.
- Throughput: one access per cycle. Back-to-back grants to either requester are allowed.
- Async reset (reset=0): owner=NONE, counter=0. f_gnt, l_gnt, mem_en and mem_we are forced to 0 while reset is low. All rvalid=0 and rdata=0.
- Reset mid-read: the pending response is discarded, and no rvalid appears after release.
- First grant is possible on the first rising edge after reset deasserts.

## Configuration
- IMEM_ARB_FAIRNESS_EN defined: a counter tracks consecutive cycles with l_gnt & f_req.
  - When the count reaches MAX_BURST and both requesters are active, fetch is granted and the counter clears.
  - The counter also clears whenever f_req=0 or f_gnt=1.
  - Worst-case fetch wait is MAX_BURST cycles.
- IMEM_ARB_FAIRNESS_EN not defined: strict loader priority and no counter. Fetch may starve indefinitely while l_req stays high.

## Test plan
- Reset hold: reset=0 with f_req=l_req=1 -> all gnt, mem_en, rvalid = 0 and rdata = 0. Release -> f_rvalid=0 on the first edge.
- Fetch-only read: mem[3]=32'h00500093, f_addr=32'h0000000C -> f_gnt same cycle, mem_addr=3; next cycle f_rvalid=1, f_rdata=32'h00500093.
- Load then fetch: loader writes 32'hDEADBEEF at byte 0x40, then fetch reads 0x40 -> f_rdata=32'hDEADBEEF. No l_rvalid for the write.
- Contention: f_req and l_req held high for 10 cycles with loader reads.
  - Fairness build, MAX_BURST=4: grant pattern L,L,L,L,F repeated. Each rvalid routes to its owner only.
  - Strict build: all L, f_gnt stays 0.
- Wrap/alignment: f_addr=32'h00001003 -> mem_addr=0 for ADDR_WIDTH=10.
- Reset mid-read: grant a fetch, assert reset before the next edge -> no f_rvalid after release.
